// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: saturating coin credit, per-item pricing and serial change return.
// Optional per-item stock counters with restock and sold_out are enabled by defining STOCK_TRACK_EN.
module vending_machine_multi #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 6,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_VEC = {6'd7, 6'd5, 6'd4, 6'd3},
  parameter int SEL_W     = $clog2(NUM_ITEMS)
`ifdef STOCK_TRACK_EN
  ,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 9
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid,
  input  logic [1:0]           coin_val,
  input  logic                 sel_valid,
  input  logic [SEL_W-1:0]     sel_item,
  input  logic                 cancel,
`ifdef STOCK_TRACK_EN
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] sold_out,
`endif
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] item_out,
  output logic                 change_out,
  output logic                 coin_reject,
  output logic                 sel_deny,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DISPENSE = 2'd2, CHANGE = 2'd3} state_e;

  localparam int CW1 = CREDIT_W + 1;
  localparam logic [CREDIT_W:0] MAX_CREDIT  = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [SEL_W:0]    NUM_ITEMS_W = (SEL_W+1)'(NUM_ITEMS);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_deny_q, sel_deny_d;

  logic [CREDIT_W:0]   coin_units, coin_sum;
  logic [CREDIT_W-1:0] price_sel;
  logic                stock_ok;
  logic                sel_ok;
  logic                honoured;

  always_comb begin
    coin_units = CW1'(1);
    case (coin_val)
      2'd0:    coin_units = CW1'(1);
      2'd1:    coin_units = CW1'(2);
      2'd2:    coin_units = CW1'(5);
      default: coin_units = CW1'(10);
    endcase
    coin_sum = {1'b0, credit_q} + coin_units;
  end

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == SEL_W'(i)) price_sel = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
    end
  end

  assign sel_ok = ({1'b0, sel_item} < NUM_ITEMS_W) && (credit_q >= price_sel) && stock_ok;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    sel_d         = sel_q;
    coin_reject_d = 1'b0;
    sel_deny_d    = 1'b0;
    honoured      = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        // A cycle taken by an honoured cancel or purchase cannot also bank a coin.
        if (cancel && state_q == COLLECT) begin
          honoured = 1'b1;
          state_d  = CHANGE;
        end else if (sel_valid) begin
          if (state_q == COLLECT && sel_ok) begin
            honoured = 1'b1;
            credit_d = credit_q - price_sel;
            sel_d    = sel_item;
            state_d  = DISPENSE;
          end else begin
            sel_deny_d = 1'b1;
          end
        end
        if (coin_valid) begin
          if (honoured || coin_sum > MAX_CREDIT) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        sel_deny_d    = sel_valid;
        state_d       = (credit_q != '0) ? CHANGE : IDLE;
      end
      default: begin
        coin_reject_d = coin_valid;
        sel_deny_d    = sel_valid;
        credit_d      = (credit_q != '0) ? credit_q - 1'b1 : '0;
        if (credit_q <= CREDIT_W'(1)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      sel_q         <= '0;
      coin_reject_q <= 1'b0;
      sel_deny_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      sel_q         <= sel_d;
      coin_reject_q <= coin_reject_d;
      sel_deny_q    <= sel_deny_d;
    end
  end

`ifdef STOCK_TRACK_EN
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  always_comb begin
    stock_ok = 1'b0;
    sold_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out[i] = (stock_q[i] == '0);
      if (sel_item == SEL_W'(i)) stock_ok = (stock_q[i] != '0);
    end
  end

  // DISPENSE only lasts one cycle, so state_d == DISPENSE marks the entry cycle.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (state_q == IDLE && restock) stock_d[i] = STOCK_W'(INIT_STOCK);
      if (state_d == DISPENSE && sel_item == SEL_W'(i)) stock_d[i] = stock_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rst) stock_q[i] <= STOCK_W'(INIT_STOCK);
      else     stock_q[i] <= stock_d[i];
    end
  end
`else
  assign stock_ok = 1'b1;
`endif

  always_comb begin
    item_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (state_q == DISPENSE && sel_q == SEL_W'(i)) item_out[i] = 1'b1;
    end
  end

  assign credit      = credit_q;
  assign change_out  = (state_q == CHANGE);
  assign busy        = (state_q == DISPENSE) || (state_q == CHANGE);
  assign coin_reject = coin_reject_q;
  assign sel_deny    = sel_deny_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: immediate-assertion checks plus a dispense scoreboard.
// Define STOCK_TRACK_EN to also build and exercise the stock-tracking ports.
module tb_vending_machine_multi;

  localparam int NUM_ITEMS = 4;
  localparam int CREDIT_W  = 6;
  localparam int SEL_W     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 coin_valid;
  logic [1:0]           coin_val;
  logic                 sel_valid;
  logic [SEL_W-1:0]     sel_item;
  logic                 cancel;
  logic [CREDIT_W-1:0]  credit;
  logic [NUM_ITEMS-1:0] item_out;
  logic                 change_out;
  logic                 coin_reject;
  logic                 sel_deny;
  logic                 busy;
  logic [1:0]           state_dbg;
`ifdef STOCK_TRACK_EN
  logic                 restock;
  logic [NUM_ITEMS-1:0] sold_out;
`endif

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
`ifdef STOCK_TRACK_EN
    .restock(restock), .sold_out(sold_out),
`endif
    .credit(credit), .item_out(item_out), .change_out(change_out),
    .coin_reject(coin_reject), .sel_deny(sel_deny), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DISP = 2'd2, S_CHANGE = 2'd3;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;
  logic [NUM_ITEMS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard: each dispense pulse must match the oldest expected item
  always @(negedge clk) begin
    if (!rst && item_out != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_item_out", 32'(item_out), 32'd0);
      end else begin
        check("item_out", 32'(item_out), 32'(exp_q.pop_front()));
      end
    end
    if (!rst && change_out) chg_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 1'b0; coin_val = 2'd0; sel_valid = 1'b0; sel_item = '0; cancel = 1'b0;
`ifdef STOCK_TRACK_EN
    restock = 1'b0;
`endif
  endtask

  task automatic put_coin(input logic [1:0] v);
    coin_valid = 1'b1; coin_val = v;
    tick();
    idle_inputs();
  endtask

  task automatic select(input logic [SEL_W-1:0] s, input bit expect_ok);
    sel_valid = 1'b1; sel_item = s;
    if (expect_ok) exp_q.push_back(NUM_ITEMS'(1) << s);
    tick();
    idle_inputs();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (state_dbg != S_IDLE && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state_dbg), 32'(S_IDLE));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_item_out", 32'(item_out), 32'd0);
    check("rst_change", 32'(change_out), 32'd0);
    check("rst_coin_reject", 32'(coin_reject), 32'd0);
    check("rst_sel_deny", 32'(sel_deny), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));

    // 1: exact credit purchase, no change
    chg_cnt = 0;
    put_coin(2'd1);
    check("t1_credit2", 32'(credit), 32'd2);
    check("t1_state", 32'(state_dbg), 32'(S_COLLECT));
    put_coin(2'd1);
    check("t1_credit4", 32'(credit), 32'd4);
    select(2'd1, 1'b1);
    check("t1_disp_credit", 32'(credit), 32'd0);
    check("t1_disp_busy", 32'(busy), 32'd1);
    tick();
    check("t1_idle", 32'(state_dbg), 32'(S_IDLE));
    check("t1_item_clear", 32'(item_out), 32'd0);
    check("t1_no_change", 32'(chg_cnt), 32'd0);

    // 2: purchase with 4 units of change
    chg_cnt = 0;
    put_coin(2'd2);
    put_coin(2'd1);
    check("t2_credit7", 32'(credit), 32'd7);
    select(2'd0, 1'b1);
    check("t2_disp_credit", 32'(credit), 32'd4);
    check("t2_disp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_change_out", 32'(change_out), 32'd1);
      check("t2_busy", 32'(busy), 32'd1);
      check("t2_credit_step", 32'(credit), 32'(4 - i));
    end
    tick();
    check("t2_final_credit", 32'(credit), 32'd0);
    check("t2_busy_low", 32'(busy), 32'd0);
    check("t2_idle", 32'(state_dbg), 32'(S_IDLE));
    check("t2_pulses", 32'(chg_cnt), 32'd4);

    // 3: insufficient credit denial, then cancel refund
    chg_cnt = 0;
    put_coin(2'd0);
    select(2'd3, 1'b0);
    check("t3_sel_deny", 32'(sel_deny), 32'd1);
    check("t3_credit_kept", 32'(credit), 32'd1);
    tick();
    check("t3_deny_pulse_end", 32'(sel_deny), 32'd0);
    cancel = 1'b1;
    tick();
    idle_inputs();
    check("t3_change_state", 32'(state_dbg), 32'(S_CHANGE));
    check("t3_change_out", 32'(change_out), 32'd1);
    tick();
    check("t3_idle", 32'(state_dbg), 32'(S_IDLE));
    check("t3_pulses", 32'(chg_cnt), 32'd1);

    // 4: saturation boundary
    for (int i = 0; i < 6; i++) put_coin(2'd3);
    check("t4_credit60", 32'(credit), 32'd60);
    put_coin(2'd3);
    check("t4_coin_reject", 32'(coin_reject), 32'd1);
    check("t4_credit_held", 32'(credit), 32'd60);
    put_coin(2'd0);
    check("t4_reject_clear", 32'(coin_reject), 32'd0);
    check("t4_credit61", 32'(credit), 32'd61);
    put_coin(2'd1);
    check("t4_credit63", 32'(credit), 32'd63);
    chg_cnt = 0;
    cancel = 1'b1;
    tick();
    idle_inputs();
    wait_idle("t4_drain_idle", 100);
    check("t4_pulses", 32'(chg_cnt), 32'd63);

    // 5: coin in the same cycle as cancel
    chg_cnt = 0;
    put_coin(2'd1);
    coin_valid = 1'b1; coin_val = 2'd2; cancel = 1'b1;
    tick();
    idle_inputs();
    check("t5_coin_reject", 32'(coin_reject), 32'd1);
    check("t5_credit", 32'(credit), 32'd2);
    check("t5_state", 32'(state_dbg), 32'(S_CHANGE));
    wait_idle("t5_idle", 10);
    check("t5_final_credit", 32'(credit), 32'd0);
    check("t5_pulses", 32'(chg_cnt), 32'd2);

    // 6: reset while returning change; inputs during CHANGE are refused
    put_coin(2'd3);
    select(2'd2, 1'b1);
    check("t6_disp_credit", 32'(credit), 32'd5);
    tick();
    check("t6_change5", 32'(credit), 32'd5);
    coin_valid = 1'b1; coin_val = 2'd0; sel_valid = 1'b1;
    tick();
    idle_inputs();
    check("t6_change4", 32'(credit), 32'd4);
    check("t6_busy_coin_reject", 32'(coin_reject), 32'd1);
    check("t6_busy_sel_deny", 32'(sel_deny), 32'd1);
    tick();
    check("t6_change3", 32'(credit), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_credit", 32'(credit), 32'd0);
    check("t6_rst_change", 32'(change_out), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_state", 32'(state_dbg), 32'(S_IDLE));

`ifdef STOCK_TRACK_EN
    check("stk_initial", 32'(sold_out), 32'd0);
    for (int i = 0; i < 9; i++) begin
      put_coin(2'd2);
      select(2'd2, 1'b1);
      tick();
    end
    check("stk_sold_out", 32'(sold_out), 32'b0100);
    put_coin(2'd2);
    select(2'd2, 1'b0);
    check("stk_sel_deny", 32'(sel_deny), 32'd1);
    check("stk_credit_kept", 32'(credit), 32'd5);
    cancel = 1'b1;
    tick();
    idle_inputs();
    wait_idle("stk_drain_idle", 20);
    restock = 1'b1;
    tick();
    idle_inputs();
    check("stk_restock", 32'(sold_out), 32'd0);
`endif

    tick();
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
